// File: rtl/ibex_pkg.sv
// Shared types for the RVFI retirement trace buffer: record layout and FSM states.
package ibex_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] rd_wdata;
        logic [4:0]  rd_addr;
        logic        trap;
    } trace_rec_t;

    typedef enum logic [1:0] {
        TB_IDLE    = 2'd0,
        TB_CAPTURE = 2'd1,
        TB_POST    = 2'd2,
        TB_DONE    = 2'd3
    } trace_state_e;

endpackage

// File: rtl/ibex_rvfi_trace_buffer.sv
// Captures RVFI retirements into a ring of records, either stop-when-full or
// circular around a PC/trap trigger, then streams them out oldest first.
module ibex_rvfi_trace_buffer
    import ibex_pkg::*;
#(
    parameter int unsigned Depth      = 16,
    parameter bit          TrapTrigEn = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     rvfi_valid_i,
    input  logic [31:0]              rvfi_pc_rdata_i,
    input  logic [31:0]              rvfi_insn_i,
    input  logic [31:0]              rvfi_rd_wdata_i,
    input  logic [4:0]               rvfi_rd_addr_i,
    input  logic                     rvfi_trap_i,
    input  logic                     arm_i,
    input  logic                     mode_i,
    input  logic                     trig_pc_en_i,
    input  logic [31:0]              trig_pc_i,
    input  logic                     trig_trap_en_i,
    input  logic [$clog2(Depth)-1:0] post_cnt_i,
    output logic                     rd_valid_o,
    input  logic                     rd_ready_i,
    output logic [101:0]             rd_data_o,
    output logic [1:0]               state_o,
    output logic [$clog2(Depth):0]   count_o,
    output logic                     overflow_o,
    output logic                     triggered_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(Depth);

    trace_state_e  state_reg, state_next;
    logic [AW-1:0] wptr_reg, wptr_next;
    logic [AW-1:0] rptr_reg, rptr_next;
    logic [AW:0]   count_reg, count_next;
    logic [AW-1:0] post_left_reg, post_left_next;
    logic [AW-1:0] post_cfg_reg, post_cfg_next;
    logic          mode_reg, mode_next;
    logic          overflow_reg, overflow_next;
    logic          triggered_reg, triggered_next;

    trace_rec_t    mem [Depth];
    trace_rec_t    wr_rec;
    logic          mem_we;
    logic          trap_trig;
    logic          trig_hit;

    generate
        if (TrapTrigEn) begin : gen_trap_trig
            assign trap_trig = trig_trap_en_i & rvfi_trap_i;
        end else begin : gen_no_trap_trig
            assign trap_trig = 1'b0;
        end
    endgenerate

    assign trig_hit = rvfi_valid_i &
                      ((trig_pc_en_i & (rvfi_pc_rdata_i == trig_pc_i)) | trap_trig);

    assign wr_rec = '{pc:       rvfi_pc_rdata_i,
                      insn:     rvfi_insn_i,
                      rd_wdata: rvfi_rd_wdata_i,
                      rd_addr:  rvfi_rd_addr_i,
                      trap:     rvfi_trap_i};

    assign mem_we = rvfi_valid_i & ((state_reg == TB_CAPTURE) | (state_reg == TB_POST));

    always_comb begin
        state_next     = state_reg;
        wptr_next      = wptr_reg;
        rptr_next      = rptr_reg;
        count_next     = count_reg;
        post_left_next = post_left_reg;
        post_cfg_next  = post_cfg_reg;
        mode_next      = mode_reg;
        overflow_next  = overflow_reg;
        triggered_next = triggered_reg;
        unique case (state_reg)
            TB_IDLE: begin
                if (arm_i) begin
                    wptr_next      = '0;
                    rptr_next      = '0;
                    count_next     = '0;
                    overflow_next  = 1'b0;
                    triggered_next = 1'b0;
                    mode_next      = mode_i;
                    post_cfg_next  = post_cnt_i;
                    state_next     = TB_CAPTURE;
                end
            end
            TB_CAPTURE, TB_POST: begin
                if (rvfi_valid_i) begin
                    wptr_next = wptr_reg + 1'b1;
                    // A full ring drops its oldest entry so count stays at Depth.
                    if (count_reg == DEPTH_CNT) begin
                        rptr_next     = rptr_reg + 1'b1;
                        overflow_next = 1'b1;
                    end else begin
                        count_next = count_reg + 1'b1;
                    end
                    if (!mode_reg) begin
                        if (count_reg == DEPTH_CNT - 1'b1) begin
                            state_next = TB_DONE;
                        end
                    end else if (state_reg == TB_CAPTURE) begin
                        if (trig_hit && !triggered_reg) begin
                            triggered_next = 1'b1;
                            if (post_cfg_reg == '0) begin
                                state_next = TB_DONE;
                            end else begin
                                post_left_next = post_cfg_reg;
                                state_next     = TB_POST;
                            end
                        end
                    end else begin
                        post_left_next = post_left_reg - 1'b1;
                        if (post_left_reg == AW'(1)) begin
                            state_next = TB_DONE;
                        end
                    end
                end
            end
            TB_DONE: begin
                if (count_reg == '0) begin
                    state_next = TB_IDLE;
                end else if (rd_ready_i) begin
                    rptr_next  = rptr_reg + 1'b1;
                    count_next = count_reg - 1'b1;
                    if (count_reg == (AW+1)'(1)) begin
                        state_next = TB_IDLE;
                    end
                end
            end
            default: state_next = TB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= TB_IDLE;
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            count_reg     <= '0;
            post_left_reg <= '0;
            post_cfg_reg  <= '0;
            mode_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            triggered_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wptr_reg      <= wptr_next;
            rptr_reg      <= rptr_next;
            count_reg     <= count_next;
            post_left_reg <= post_left_next;
            post_cfg_reg  <= post_cfg_next;
            mode_reg      <= mode_next;
            overflow_reg  <= overflow_next;
            triggered_reg <= triggered_next;
        end
    end

    // Storage is intentionally left unreset; readout is gated by count.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[wptr_reg] <= wr_rec;
        end
    end

    assign rd_data_o   = mem[rptr_reg];
    assign rd_valid_o  = (state_reg == TB_DONE) && (count_reg != '0);
    assign state_o     = state_reg;
    assign count_o     = count_reg;
    assign overflow_o  = overflow_reg;
    assign triggered_o = triggered_reg;

endmodule

// File: tb/tb_ibex_rvfi_trace_buffer.sv
// Randomized and directed bench for the RVFI trace buffer, checked every cycle
// against a queue-based model of the capture/readout rules.
module tb_ibex_rvfi_trace_buffer;

    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         valid = 1'b0;
    logic [31:0]  pc = '0, insn = '0, wdata = '0;
    logic [4:0]   rd_addr = '0;
    logic         trap = 1'b0;
    logic         arm = 1'b0, mode = 1'b0;
    logic         tpc_en = 1'b0, ttrap_en = 1'b0;
    logic [31:0]  tpc = '0;
    logic [3:0]   post = '0;
    logic         rd_ready = 1'b0;
    logic         rd_valid;
    logic [101:0] rd_data;
    logic [1:0]   state;
    logic [4:0]   count;
    logic         overflow, triggered;

    ibex_rvfi_trace_buffer #(.Depth(DEPTH), .TrapTrigEn(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .rvfi_valid_i(valid),
        .rvfi_pc_rdata_i(pc), .rvfi_insn_i(insn), .rvfi_rd_wdata_i(wdata),
        .rvfi_rd_addr_i(rd_addr), .rvfi_trap_i(trap),
        .arm_i(arm), .mode_i(mode), .trig_pc_en_i(tpc_en), .trig_pc_i(tpc),
        .trig_trap_en_i(ttrap_en), .post_cnt_i(post),
        .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
        .state_o(state), .count_o(count), .overflow_o(overflow), .triggered_o(triggered)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Behavioural model: the buffer is a queue of at most DEPTH records.
    int           m_state = 0;
    logic [101:0] m_q[$];
    bit           m_over = 0, m_trig = 0, m_mode = 0;
    int           m_cfg = 0, m_left = 0;
    logic [101:0] got[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [101:0] rec;
        bit hit;
        if (rst) begin
            m_state = 0; m_q.delete(); m_over = 0; m_trig = 0; m_left = 0;
            return;
        end
        case (m_state)
            0: if (arm) begin
                m_q.delete(); m_over = 0; m_trig = 0;
                m_mode = mode; m_cfg = int'(post); m_state = 1;
            end
            1, 2: if (valid) begin
                rec = {pc, insn, wdata, rd_addr, trap};
                m_q.push_back(rec);
                if (m_q.size() > DEPTH) begin
                    void'(m_q.pop_front());
                    m_over = 1;
                end
                hit = (tpc_en && pc == tpc) || (ttrap_en && trap);
                if (!m_mode) begin
                    if (m_q.size() == DEPTH) m_state = 3;
                end else if (m_state == 1) begin
                    if (hit && !m_trig) begin
                        m_trig = 1;
                        if (m_cfg == 0) m_state = 3;
                        else begin m_left = m_cfg; m_state = 2; end
                    end
                end else begin
                    m_left--;
                    if (m_left == 0) m_state = 3;
                end
            end
            default: begin
                if (m_q.size() == 0) m_state = 0;
                else if (rd_ready) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_state = 0;
                end
            end
        endcase
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("state", 128'(state), 128'(m_state));
            check("count", 128'(count), 128'(m_q.size()));
            check("overflow", 128'(overflow), 128'(m_over));
            check("triggered", 128'(triggered), 128'(m_trig));
            check("rd_valid", 128'(rd_valid), 128'(m_state == 3 && m_q.size() != 0));
            if (m_state == 3 && m_q.size() != 0)
                check("rd_data", 128'(rd_data), 128'(m_q[0]));
        end
    end

    task automatic cycle();
        #1;
        if (rd_valid && rd_ready) got.push_back(rd_data);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1; cycle(); rst = 0;
    endtask

    task automatic do_arm(input bit md, input logic [3:0] pc_post);
        mode = md; post = pc_post; arm = 1; cycle(); arm = 0;
    endtask

    task automatic retire(input logic [31:0] p, input bit t);
        valid = 1; pc = p; trap = t;
        insn = $urandom; wdata = $urandom; rd_addr = 5'($urandom);
        cycle();
        valid = 0; trap = 0;
    endtask

    task automatic drain(input int budget, input bit toggle);
        int i;
        got.delete();
        for (i = 0; i < budget && state != 2'd0; i++) begin
            rd_ready = toggle ? ((i % 2) == 0) : 1'b1;
            cycle();
        end
        rd_ready = 0;
        check("drain_timeout", 128'(state), 128'(0));
    endtask

    initial begin
        do_reset();
        chk_en = 1'b1;
        check("reset_state", 128'(state), 128'(0));
        check("reset_count", 128'(count), 128'(0));

        // Stop-when-full: 20 retirements, only the first 16 kept.
        do_arm(1'b0, 4'd0);
        for (int k = 0; k < 20; k++) begin
            retire(32'h100 + 32'(4 * k), 1'b0);
            if (k == 15) begin
                check("a_done", 128'(state), 128'(3));
                check("a_count16", 128'(count), 128'(16));
            end
        end
        drain(40, 1'b0);
        check("a_nread", 128'(got.size()), 128'(16));
        for (int i = 0; i < got.size(); i++)
            check("a_pc", 128'(got[i][101:70]), 128'(32'h100 + 32'(4 * i)));

        // Circular with PC trigger at #25 and three post records.
        tpc_en = 1; tpc = 32'h200;
        do_arm(1'b1, 4'd3);
        for (int k = 0; k < 40; k++)
            retire((k == 25) ? 32'h200 : 32'h1000 + 32'(4 * k), 1'b0);
        check("b_overflow", 128'(overflow), 128'(1));
        check("b_triggered", 128'(triggered), 128'(1));
        drain(40, 1'b0);
        check("b_nread", 128'(got.size()), 128'(16));
        if (got.size() == 16) begin
            check("b_first", 128'(got[0][101:70]), 128'(32'h1034));
            check("b_last", 128'(got[15][101:70]), 128'(32'h1070));
        end
        tpc_en = 0;

        // Trap trigger with no post records.
        ttrap_en = 1;
        do_arm(1'b1, 4'd0);
        for (int k = 0; k < 6; k++) retire(32'h3000 + 32'(4 * k), k == 5);
        check("c_done", 128'(state), 128'(3));
        drain(20, 1'b0);
        check("c_nread", 128'(got.size()), 128'(6));
        if (got.size() == 6) begin
            check("c_trap", 128'(got[5][0]), 128'(1));
            check("c_lastpc", 128'(got[5][101:70]), 128'(32'h3014));
        end
        ttrap_en = 0;

        // Readout with ready toggling.
        do_arm(1'b0, 4'd0);
        for (int k = 0; k < 16; k++) retire(32'h4000 + 32'(4 * k), 1'b0);
        drain(64, 1'b1);
        check("d_nread", 128'(got.size()), 128'(16));
        for (int i = 0; i < got.size(); i++)
            check("d_pc", 128'(got[i][101:70]), 128'(32'h4000 + 32'(4 * i)));

        // Reset mid-POST, then mid-readout, then a clean re-arm.
        tpc_en = 1; tpc = 32'h5010;
        do_arm(1'b1, 4'd5);
        for (int k = 0; k < 6; k++) retire(32'h5000 + 32'(4 * k), 1'b0);
        check("e_post", 128'(state), 128'(2));
        do_reset();
        check("e_rst1_state", 128'(state), 128'(0));
        check("e_rst1_count", 128'(count), 128'(0));
        tpc_en = 0;
        do_arm(1'b0, 4'd0);
        for (int k = 0; k < 16; k++) retire(32'h6000 + 32'(4 * k), 1'b0);
        rd_ready = 1; cycle(); cycle(); cycle(); rd_ready = 0;
        check("e_partial", 128'(count), 128'(13));
        do_reset();
        check("e_rst2_state", 128'(state), 128'(0));
        check("e_rst2_valid", 128'(rd_valid), 128'(0));
        do_arm(1'b0, 4'd0);
        for (int k = 0; k < 16; k++) retire(32'h7000 + 32'(4 * k), 1'b0);
        drain(40, 1'b0);
        check("e_rearm_nread", 128'(got.size()), 128'(16));

        // Arm ignored in CAPTURE and DONE.
        do_arm(1'b0, 4'd0);
        for (int k = 0; k < 3; k++) retire(32'h8000 + 32'(4 * k), 1'b0);
        do_arm(1'b1, 4'd2);
        check("f_cap_count", 128'(count), 128'(3));
        check("f_cap_state", 128'(state), 128'(1));
        for (int k = 3; k < 16; k++) retire(32'h8000 + 32'(4 * k), 1'b0);
        do_arm(1'b1, 4'd2);
        check("f_done_count", 128'(count), 128'(16));
        drain(40, 1'b0);
        check("f_nread", 128'(got.size()), 128'(16));

        // Randomized sessions.
        for (int s = 0; s < 40; s++) begin
            tpc_en = 1'($urandom); ttrap_en = 1'($urandom);
            tpc = 32'h100 + 32'(4 * $urandom_range(0, 15));
            do_arm(1'($urandom), 4'($urandom));
            for (int c = 0; c < 200 && m_state != 0; c++) begin
                valid = ($urandom_range(0, 9) < 7);
                pc = 32'h100 + 32'(4 * $urandom_range(0, 15));
                insn = $urandom; wdata = $urandom; rd_addr = 5'($urandom);
                trap = ($urandom_range(0, 15) == 0);
                rd_ready = 1'($urandom);
                arm = ($urandom_range(0, 7) == 0);
                mode = 1'($urandom); post = 4'($urandom);
                rst = ($urandom_range(0, 99) == 0);
                cycle();
            end
            valid = 0; arm = 0; rd_ready = 0; trap = 0;
            if (m_state != 0) do_reset();
            rst = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
